counter_sequencer: RTL and testbench

FSM controller that sequences the 4-bit hex up/down counter datapath (load / enable / direction) from board switches. It loads a start value, runs the counter between programmable limits in one of four modes, and reports status on LEDs. Sits in top between the SWI decode and the counter register; the counter value feeds back for terminal-count detection.

---
 rtl/counter_sequencer.sv | 134 +++++++++++++
 tb/tb_counter_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// counter_sequencer: FSM that drives the hex up/down counter datapath
// (load / enable / direction) from the board switches. It loads a start
// value, runs the counter between the lo and hi limits in one of four modes,
// and reports progress on the LEDs. The datapath's current count comes back
// in so the sequencer can see when a limit has been reached.
module counter_sequencer #(
  parameter int NBITS_COUNT = 4,
  parameter int TICK_DIV    = 4
) (
  input  logic                   clk_2,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [1:0]             mode,
  input  logic [NBITS_COUNT-1:0] lo,
  input  logic [NBITS_COUNT-1:0] hi,
  input  logic [NBITS_COUNT-1:0] count,
  output logic                   cnt_load,
  output logic [NBITS_COUNT-1:0] cnt_data,
  output logic                   cnt_en,
  output logic                   cnt_up,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             state
);

  // The prescaler is always at least one bit wide, so TICK_DIV == 1 still
  // builds; in that case the prescaler stays at zero and every cycle ticks.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    UP_ONCE   = 2'd0,
    DOWN_ONCE = 2'd1,
    PINGPONG  = 2'd2,
    STEP      = 2'd3
  } mode_t;

  state_t        state_q;
  mode_t         mode_q;
  logic [PW-1:0] presc_q;
  logic          dir_q;
  logic          start_q;
  logic          err_q;

  logic startRise;
  logic timed;
  logic tick;
  logic atLimit;

  // A command is the rising edge of the start switch, seen against the
  // previous cycle's sample.
  assign startRise = start & ~start_q;

  // STEP advances on start edges; every other mode is paced by the prescaler.
  assign timed   = (mode_q != STEP);
  assign tick    = (state_q == RUN) & (timed ? (presc_q == TICK_LAST) : startRise);
  assign atLimit = dir_q ? (count == hi) : (count == lo);

  // Strobes are combinational so that stop suppresses them in the same
  // cycle, and so that an asynchronous reset drops them immediately.
  assign cnt_load = (state_q == LOAD) & ~stop;
  assign cnt_data = (state_q == LOAD) ? ((mode_q == DOWN_ONCE) ? hi : lo) : '0;
  assign cnt_en   = tick & ~atLimit & ~stop;
  assign cnt_up   = dir_q;
  assign busy     = (state_q == LOAD) | (state_q == RUN);
  assign done     = (state_q == DONE);
  assign err      = err_q;
  assign state    = state_q;

  // Sequencer state, latched mode, direction, prescaler, start sample and the
  // sticky error flag. Stop wins over any tick or start edge in LOAD/RUN.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= UP_ONCE;
      presc_q <= '0;
      dir_q   <= 1'b1;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      start_q <= start;
      case (state_q)
        IDLE: begin
          if (startRise) begin
            if (lo > hi) begin
              err_q <= 1'b1;
            end else begin
              err_q   <= 1'b0;
              mode_q  <= mode_t'(mode);
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          presc_q <= '0;
          dir_q   <= (mode_q != DOWN_ONCE);
          state_q <= stop ? IDLE : RUN;
        end
        RUN: begin
          if (stop) begin
            state_q <= IDLE;
          end else begin
            if (timed) begin
              presc_q <= tick ? '0 : presc_q + 1'b1;
            end
            if (tick && atLimit) begin
              if (mode_q == PINGPONG) begin
                dir_q <= ~dir_q;
              end else begin
                state_q <= DONE;
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: drives counter_sequencer together with a simple
// counter-register stand-in. Each command pushes its expected strobe events
// (load / enable / done, with the cycle they must appear in) into a queue,
// and an independent monitor pops and compares every strobe the DUT shows.
module tb_counter_sequencer;

  localparam int NB = 4;
  localparam int TD = 4;

  localparam int K_LOAD = 0;
  localparam int K_EN   = 1;
  localparam int K_DONE = 2;

  localparam int M_UP   = 0;
  localparam int M_DOWN = 1;
  localparam int M_PP   = 2;
  localparam int M_STEP = 3;

  localparam int NO_STOP = 1000000000;

  logic          clk_2 = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop  = 1'b0;
  logic [1:0]    mode  = 2'd0;
  logic [NB-1:0] lo    = '0;
  logic [NB-1:0] hi    = '0;
  logic [NB-1:0] count;
  logic          cnt_load;
  logic [NB-1:0] cnt_data;
  logic          cnt_en;
  logic          cnt_up;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    state;

  logic [NB-1:0] cnt = '0;
  int cyc = 0;
  int nVectors = 0;
  int nMiscompares = 0;
  int modelCnt = 0;

  typedef struct {
    int cyc;
    int kind;
    int val;
    int up;
  } ev_t;

  ev_t expQ[$];

  int  monK;
  int  monV;
  int  monU;
  ev_t monE;

  assign count = cnt;

  counter_sequencer #(
    .NBITS_COUNT(NB),
    .TICK_DIV   (TD)
  ) dut (
    .clk_2   (clk_2),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .mode    (mode),
    .lo      (lo),
    .hi      (hi),
    .count   (count),
    .cnt_load(cnt_load),
    .cnt_data(cnt_data),
    .cnt_en  (cnt_en),
    .cnt_up  (cnt_up),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .state   (state)
  );

  // Free-running clock.
  always #5 clk_2 = ~clk_2;

  // Cycle index: during cycle n, n rising edges have occurred.
  always @(posedge clk_2) cyc <= cyc + 1;

  // Stand-in for the counter register the sequencer controls.
  always @(posedge clk_2) begin
    if (cnt_load) cnt <= cnt_data;
    else if (cnt_en) cnt <= cnt_up ? cnt + 4'd1 : cnt - 4'd1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nVectors++;
    if (actual != expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic pushEv(input int c, input int k, input int v, input int u);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.val  = v;
    e.up   = u;
    expQ.push_back(e);
  endtask

  // Tick-level model of a timed run: ticks every TD cycles after the load
  // cycle; at a limit either finish or reverse; nothing at or after stopCyc.
  task automatic pushTimed(input int m, input int l, input int h, input int lc,
                           input int stopCyc, output int endCyc);
    int p;
    int dir;
    int t;
    endCyc = stopCyc;
    if (lc >= stopCyc) return;
    p   = (m == M_DOWN) ? h : l;
    dir = (m == M_DOWN) ? 0 : 1;
    pushEv(lc, K_LOAD, p, 0);
    t = lc + TD;
    while (t < stopCyc) begin
      if ((dir == 1) ? (p == h) : (p == l)) begin
        if (m == M_PP) begin
          dir = 1 - dir;
        end else begin
          pushEv(t + 1, K_DONE, p, 0);
          endCyc = t + 1;
          break;
        end
      end else begin
        pushEv(t, K_EN, p, dir);
        p = (dir == 1) ? p + 1 : p - 1;
      end
      t += TD;
    end
    modelCnt = p;
  endtask

  // One accepted command: mode m, limits l..h, optional stop stopRel cycles
  // after the load cycle (negative means no stop).
  task automatic applyStimulus(input int m, input int l, input int h, input int stopRel);
    int lc;
    int stopCyc;
    int endCyc;
    int c;
    int p;
    int hold;
    bit fin;
    @(posedge clk_2); #1;
    mode  = 2'(m);
    lo    = 4'(l);
    hi    = 4'(h);
    start = 1'b1;
    lc = cyc + 1;
    stopCyc = (stopRel < 0) ? NO_STOP : lc + stopRel;
    endCyc = lc;
    if (m != M_STEP) pushTimed(m, l, h, lc, stopCyc, endCyc);
    else pushEv(lc, K_LOAD, l, 0);
    @(posedge clk_2); #1;
    start = 1'b0;
    mode  = 2'($urandom_range(0, 3));
    checkOutput("accept_busy", busy, 1);
    checkOutput("accept_state", state, 1);
    checkOutput("accept_err", err, 0);
    if (m != M_STEP) begin
      while (cyc < endCyc + 1) begin
        stop = (cyc == stopCyc);
        @(posedge clk_2); #1;
        mode = 2'($urandom_range(0, 3));
      end
      stop = 1'b0;
    end else begin
      p = l;
      fin = 1'b0;
      c = lc + 1 + $urandom_range(0, 2);
      while (!fin) begin
        while (cyc < c) begin
          @(posedge clk_2); #1;
          mode = 2'($urandom_range(0, 3));
        end
        start = 1'b1;
        if (p == h) begin
          pushEv(c + 1, K_DONE, p, 0);
          endCyc = c + 1;
          fin = 1'b1;
        end else begin
          pushEv(c, K_EN, p, 1);
        end
        hold = $urandom_range(1, 3);
        repeat (hold) begin
          @(posedge clk_2); #1;
        end
        start = 1'b0;
        if (!fin) begin
          p++;
          c = cyc + $urandom_range(1, 2);
        end
      end
      while (cyc < endCyc + 1) begin
        @(posedge clk_2); #1;
      end
      modelCnt = p;
    end
    checkOutput("end_state", state, 0);
    checkOutput("end_busy", busy, 0);
    checkOutput("end_count", cnt, modelCnt);
    checkOutput("pending_events", expQ.size(), 0);
  endtask

  // A start edge with lo > hi must only raise err and stay in IDLE.
  task automatic applyBadStart(input int l, input int h);
    @(posedge clk_2); #1;
    lo    = 4'(l);
    hi    = 4'(h);
    mode  = 2'($urandom_range(0, 3));
    start = 1'b1;
    @(posedge clk_2); #1;
    start = 1'b0;
    checkOutput("err_set", err, 1);
    checkOutput("err_state", state, 0);
    checkOutput("err_busy", busy, 0);
    repeat (3) begin
      @(posedge clk_2); #1;
    end
    checkOutput("err_sticky", err, 1);
    checkOutput("err_count", cnt, modelCnt);
  endtask

  // Asynchronous reset between clock edges in the middle of an UP_ONCE run.
  task automatic applyResetMidRun();
    int lc;
    int endCyc;
    @(posedge clk_2); #1;
    mode  = 2'(M_UP);
    lo    = 4'd0;
    hi    = 4'd15;
    start = 1'b1;
    lc = cyc + 1;
    pushTimed(M_UP, 0, 15, lc, lc + 10, endCyc);
    while (cyc < lc + 10) begin
      @(posedge clk_2); #1;
      start = 1'b0;
    end
    checkOutput("pre_reset_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cnt_en", cnt_en, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_state", state, 0);
    checkOutput("rst_cnt_up", cnt_up, 1);
    @(posedge clk_2); #3;
    reset = 1'b0;
    @(posedge clk_2); #1;
    checkOutput("post_rst_state", state, 0);
    checkOutput("post_rst_count", cnt, modelCnt);
    checkOutput("post_rst_pending", expQ.size(), 0);
  endtask

  // Monitor: every strobe the DUT presents must match the next expected event.
  always @(negedge clk_2) begin
    if (!reset && (cnt_load || cnt_en || done)) begin
      if (int'(cnt_load) + int'(cnt_en) + int'(done) > 1) begin
        nVectors++;
        nMiscompares++;
        $display("[TB] FAIL strobe_overlap: load=%0b en=%0b done=%0b at cycle %0d, required at most one",
                 cnt_load, cnt_en, done, cyc);
      end
      monK = cnt_load ? K_LOAD : (cnt_en ? K_EN : K_DONE);
      monV = cnt_load ? int'(cnt_data) : int'(count);
      monU = cnt_en ? int'(cnt_up) : 0;
      nVectors++;
      if (expQ.size() == 0) begin
        nMiscompares++;
        $display("[TB] FAIL unexpected_event: got kind=%0d val=%0d up=%0d at cycle %0d, required none",
                 monK, monV, monU, cyc);
      end else begin
        monE = expQ.pop_front();
        if (monE.cyc != cyc || monE.kind != monK || monE.val != monV || monE.up != monU) begin
          nMiscompares++;
          $display("[TB] FAIL event: got kind=%0d val=%0d up=%0d cycle=%0d, required kind=%0d val=%0d up=%0d cycle=%0d",
                   monK, monV, monU, cyc, monE.kind, monE.val, monE.up, monE.cyc);
        end
      end
    end
  end

  // Absolute time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios first, then randomized commands.
  initial begin
    int m;
    int a;
    int b;
    int l;
    int h;
    int sr;
    reset = 1'b1;
    repeat (2) @(posedge clk_2);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("reset_state", state, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_cnt_up", cnt_up, 1);
    checkOutput("reset_cnt_data", cnt_data, 0);
    checkOutput("reset_cnt_load", cnt_load, 0);
    checkOutput("reset_cnt_en", cnt_en, 0);

    applyStimulus(M_UP, 3, 6, -1);
    applyStimulus(M_DOWN, 2, 9, -1);
    applyStimulus(M_PP, 0, 2, 40);
    applyStimulus(M_STEP, 5, 7, -1);
    applyBadStart(8, 4);
    applyStimulus(M_UP, 4, 8, -1);
    applyResetMidRun();
    applyStimulus(M_UP, 5, 5, -1);
    applyStimulus(M_PP, 6, 6, 13);
    applyStimulus(M_DOWN, 1, 12, 0);

    for (int i = 0; i < 16; i++) begin
      m = $urandom_range(0, 3);
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      l = (a < b) ? a : b;
      h = (a < b) ? b : a;
      if (m == M_PP) sr = $urandom_range(0, 60);
      else if (m != M_STEP && $urandom_range(0, 3) == 0) sr = $urandom_range(0, 30);
      else sr = -1;
      if (a != b && $urandom_range(0, 5) == 0) applyBadStart(h, l);
      applyStimulus(m, l, h, sr);
    end

    repeat (3) @(posedge clk_2);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
